// File: rtl/rx_ip.sv
// IPv4 receive header parser: validates a fixed 20-byte header, captures its fields,
// and forwards the payload with zero latency while trimming Ethernet padding.
module rx_ip #(
    parameter int CHECK_DEST = 1,
    parameter int HDR_BYTES  = 20
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_areset,
    input  logic        ip_enable,
    input  logic [31:0] local_ip,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [31:0] IP_SrcAddr,
    output logic [31:0] IP_DestAddr,
    output logic [15:0] IP_TotLen,
    output logic [7:0]  IP_Protocol,
    output logic        hdr_valid,
    output logic        hdr_err
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, DROP} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_pay;
    logic        r_first;
    logic [7:0]  r_b0;
    logic [7:0]  r_hi;
    logic [15:0] r_sum;
    logic [15:0] r_totlen_s;
    logic [7:0]  r_proto_s;
    logic [31:0] r_src_s;
    logic [23:0] r_dst_s;
    logic [31:0] r_ip_src;
    logic [31:0] r_ip_dst;
    logic [15:0] r_ip_len;
    logic [7:0]  r_ip_proto;
    logic        r_hdr_valid;
    logic        r_hdr_err;

    state_t      w_state;
    logic        w_bypass;
    logic        w_beat;
    logic [16:0] w_word_sum;
    logic [15:0] w_sum_fold;
    logic [31:0] w_dest;
    logic        w_pass;
    logic        w_last_hdr;

    // Reset forces the combinational view to IDLE so outputs are quiet before the first edge.
    assign w_state  = s_axis_areset ? IDLE : r_state;
    assign w_bypass = (w_state == IDLE) && !ip_enable;
    assign w_beat   = s_axis_tvalid && s_axis_tready;

    assign w_word_sum = {1'b0, r_sum} + {1'b0, r_hi, s_axis_tdata};
    assign w_sum_fold = w_word_sum[15:0] + {15'd0, w_word_sum[16]};
    assign w_dest     = {r_dst_s, s_axis_tdata};
    assign w_last_hdr = (r_cnt == 5'(HDR_BYTES - 1));
    assign w_pass     = (r_b0 == 8'h45) && (w_sum_fold == 16'hFFFF) &&
                        (r_totlen_s >= 16'(HDR_BYTES)) &&
                        ((CHECK_DEST == 0) || (w_dest == local_ip));

    always_comb begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = 1'b1;
        if (w_bypass) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = s_axis_tlast;
            m_axis_tuser  = s_axis_tuser;
            s_axis_tready = m_axis_tready;
        end else if (w_state == DATA) begin
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tlast  = (r_pay == 16'd1) || s_axis_tlast;
            m_axis_tuser  = r_first;
            s_axis_tready = m_axis_tready;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pay       <= '0;
            r_first     <= 1'b0;
            r_b0        <= '0;
            r_hi        <= '0;
            r_sum       <= '0;
            r_totlen_s  <= '0;
            r_proto_s   <= '0;
            r_src_s     <= '0;
            r_dst_s     <= '0;
            r_ip_src    <= '0;
            r_ip_dst    <= '0;
            r_ip_len    <= '0;
            r_ip_proto  <= '0;
            r_hdr_valid <= 1'b0;
            r_hdr_err   <= 1'b0;
        end else begin
            r_hdr_valid <= 1'b0;
            r_hdr_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ip_enable && w_beat && s_axis_tuser) begin
                        r_b0  <= s_axis_tdata;
                        r_hi  <= s_axis_tdata;
                        r_sum <= '0;
                        r_cnt <= 5'd1;
                        if (s_axis_tlast) r_hdr_err <= 1'b1;
                        else              r_state   <= HEADER;
                    end
                end
                HEADER: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 5'd1;
                        // Odd bytes complete a 16-bit word, even bytes wait as its high half.
                        if (r_cnt[0]) r_sum <= w_sum_fold;
                        else          r_hi  <= s_axis_tdata;
                        case (r_cnt)
                            5'd2:  r_totlen_s[15:8] <= s_axis_tdata;
                            5'd3:  r_totlen_s[7:0]  <= s_axis_tdata;
                            5'd9:  r_proto_s        <= s_axis_tdata;
                            5'd12: r_src_s[31:24]   <= s_axis_tdata;
                            5'd13: r_src_s[23:16]   <= s_axis_tdata;
                            5'd14: r_src_s[15:8]    <= s_axis_tdata;
                            5'd15: r_src_s[7:0]     <= s_axis_tdata;
                            5'd16: r_dst_s[23:16]   <= s_axis_tdata;
                            5'd17: r_dst_s[15:8]    <= s_axis_tdata;
                            5'd18: r_dst_s[7:0]     <= s_axis_tdata;
                            default: ;
                        endcase
                        if (w_last_hdr) begin
                            if (w_pass) begin
                                r_hdr_valid <= 1'b1;
                                r_ip_src    <= r_src_s;
                                r_ip_dst    <= w_dest;
                                r_ip_len    <= r_totlen_s;
                                r_ip_proto  <= r_proto_s;
                                r_pay       <= r_totlen_s - 16'(HDR_BYTES);
                                r_first     <= 1'b1;
                                if (s_axis_tlast)
                                    r_state <= IDLE;
                                else if (r_totlen_s == 16'(HDR_BYTES))
                                    r_state <= DROP;
                                else
                                    r_state <= DATA;
                            end else begin
                                r_hdr_err <= 1'b1;
                                r_state   <= s_axis_tlast ? IDLE : DROP;
                            end
                        end else if (s_axis_tlast) begin
                            r_hdr_err <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_beat) begin
                        r_first <= 1'b0;
                        r_pay   <= r_pay - 16'd1;
                        if (s_axis_tlast)         r_state <= IDLE;
                        else if (r_pay == 16'd1)  r_state <= DROP;
                    end
                end
                DROP: begin
                    if (w_beat && s_axis_tlast) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign IP_SrcAddr  = r_ip_src;
    assign IP_DestAddr = r_ip_dst;
    assign IP_TotLen   = r_ip_len;
    assign IP_Protocol = r_ip_proto;
    assign hdr_valid   = r_hdr_valid;
    assign hdr_err     = r_hdr_err;

endmodule
